depacketer: RTL and testbench
=============================

# depacketer

Receive-side counterpart of the packet encoder. Accepts 64-bit network packets over a valid/ready handshake, discards packets that are invalid or not addressed to this node, buffers accepted packets in a small FIFO, and presents the decoded header fields and payload to the local compute logic over a second valid/ready handshake. It sits between the router ejection port and the reduction/collective engine.

## Interface
Parameters:
- LocalNode, 0, 3-bit node ID of this endpoint; matched against the dst field.
- FifoDepth, 4, buffer entries; power of two, 2..16.
- CountWidth, 16, width of the drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  packet present on in_packet
- in_packet  in  64  packet word
- in_ready  out  1  block can consume in_packet this cycle
- out_valid  out  1  decoded packet at FIFO head
- out_ready  in  1  consumer takes head this cycle
- out_payload  out  32  bits 31:0
- out_op  out  5  bits 36:32
- out_rank  out  3  bits 39:37
- out_root  out  3  bits 42:40
- out_commsize  out  3  bits 45:43
- out_index  out  4  bits 49:46
- out_algtype  out  2  bits 51:50
- out_pkttype  out  4  bits 55:52
- out_src  out  3  bits 61:59
- out_reduction  out  1  bit 62
- drop_pulse  out  1  one-cycle strobe per dropped packet
- drop_count  out  CountWidth  saturating count of dropped packets

## Operation
- Packet layout: 63 valid, 62 reduction, 61:59 src, 58:56 dst, 55:52 packet type, 51:50 alg type, 49:46 index, 45:43 commsize, 42:40 root, 39:37 rank, 36:32 op, 31:0 payload.
- Handshake on both sides: transfer occurs when valid && ready in the same cycle. Valid, once raised, is never conditioned on ready.
- Consumed packet with bit 63 = 1 and dst == LocalNode: pushed into the FIFO (bits 62:59 and 55:0 stored; valid and dst are not stored).
- Consumed packet failing either check: discarded, never enters the FIFO, counts as a drop.
- in_ready = !rst && (count != FifoDepth). Drops also require in_ready (no bypass when full).
- out_valid = (count != 0). All out_* field ports show the head entry when out_valid = 1 and are forced to 0 when out_valid = 0.
- Pop on out_valid && out_ready. Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo FifoDepth.
- drop_count increments per drop and saturates at all-ones; it never wraps.

## Timing
- Reset values: count 0, pointers 0, out_valid 0, all out_* fields 0, in_ready 0 while rst is high, drop_pulse 0, drop_count 0.
- Latency: a packet accepted in cycle N appears at the head in cycle N+1 if the FIFO was empty. There is no combinational in->out pass-through.
- drop_pulse is asserted in cycle N+1 for a drop in cycle N.
- in_ready depends only on registered state, not on out_ready. A pop in the cycle the FIFO is full frees space from cycle N+1.
- rst mid-stream flushes all buffered entries and the drop counter. A packet presented in the rst cycle is not consumed.
- Throughput: one packet per cycle when the consumer holds out_ready high.

## Configuration
- DEPACKETER_STATS_EN defined: drop_count and drop_pulse behave as specified above.
- DEPACKETER_STATS_EN undefined: the counter logic is not compiled in. drop_count and drop_pulse are tied to 0. Filtering and discard behaviour are unchanged.

## Structure
- Shared package pkt_pkg holds:
  - field position and width constants (PayloadLen, opPos, RankPos, IndexPos, PacketTypePos, DstPos, SrcPos, ReductionBitPos, ValidBitPos, and the others);
  - a packed packet struct typedef;
  - the packet-type enumeration.
- The encoder migrates to pkt_pkg as well.
- One sub-module, pkt_fifo: a parameterised width/depth synchronous FIFO with count, full and empty. The filter, decode and stats logic stay in depacketer.

## Test plan
- Reset, then one packet {valid=1, dst=LocalNode=0, src=5, op=3, payload=0xDEADBEEF} -> out_valid = 1 on the next cycle with out_src = 5, out_op = 3, out_payload = 0xDEADBEEF; drop_count = 0.
- Packet with dst = 2 (LocalNode = 0), then a packet with bit 63 = 0 -> neither appears at the output; drop_pulse fires twice; drop_count = 2.
- out_ready held 0, 5 matching packets offered (FifoDepth = 4) -> 4 accepted, in_ready = 0 from the cycle after the 4th; the 5th is held. Raise out_ready -> all 5 emerge in order.
- Continuous stream with out_ready = 1 and simultaneous push/pop every cycle -> count stays at 1, no bubbles, order preserved across pointer wrap.
- Assert rst with 3 entries buffered -> next cycle out_valid = 0, all fields 0, in_ready = 1 after rst deasserts.
- CountWidth = 4 with 20 drops -> drop_count holds at 15. Build without DEPACKETER_STATS_EN -> drop_count stays 0.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared packet definitions for the encoder/depacketer pair: field positions
// and widths, the on-wire packet struct, the buffered entry struct and the
// packet-type enumeration.
package pkt_pkg;

    localparam int unsigned PacketLen       = 64;
    localparam int unsigned PayloadLen      = 32;
    localparam int unsigned PayloadPos      = 0;
    localparam int unsigned OpLen           = 5;
    localparam int unsigned OpPos           = 32;
    localparam int unsigned RankLen         = 3;
    localparam int unsigned RankPos         = 37;
    localparam int unsigned RootLen         = 3;
    localparam int unsigned RootPos         = 40;
    localparam int unsigned CommSizeLen     = 3;
    localparam int unsigned CommSizePos     = 43;
    localparam int unsigned IndexLen        = 4;
    localparam int unsigned IndexPos        = 46;
    localparam int unsigned AlgTypeLen      = 2;
    localparam int unsigned AlgTypePos      = 50;
    localparam int unsigned PacketTypeLen   = 4;
    localparam int unsigned PacketTypePos   = 52;
    localparam int unsigned NodeIdLen       = 3;
    localparam int unsigned DstPos          = 56;
    localparam int unsigned SrcPos          = 59;
    localparam int unsigned ReductionBitPos = 62;
    localparam int unsigned ValidBitPos     = 63;

    typedef enum logic [PacketTypeLen-1:0] {
        PKT_DATA    = 4'd0,
        PKT_REDUCE  = 4'd1,
        PKT_BCAST   = 4'd2,
        PKT_GATHER  = 4'd3,
        PKT_BARRIER = 4'd4
    } pkt_type_e;

    // On-wire packet, MSB first.
    typedef struct packed {
        logic                     valid;
        logic                     reduction;
        logic [NodeIdLen-1:0]     src;
        logic [NodeIdLen-1:0]     dst;
        logic [PacketTypeLen-1:0] pkttype;
        logic [AlgTypeLen-1:0]    algtype;
        logic [IndexLen-1:0]      index;
        logic [CommSizeLen-1:0]   commsize;
        logic [RootLen-1:0]       root;
        logic [RankLen-1:0]       rank;
        logic [OpLen-1:0]         op;
        logic [PayloadLen-1:0]    payload;
    } packet_t;

    // Buffered form: valid and dst are implied by having passed the filter.
    typedef struct packed {
        logic                     reduction;
        logic [NodeIdLen-1:0]     src;
        logic [PacketTypeLen-1:0] pkttype;
        logic [AlgTypeLen-1:0]    algtype;
        logic [IndexLen-1:0]      index;
        logic [CommSizeLen-1:0]   commsize;
        logic [RootLen-1:0]       root;
        logic [RankLen-1:0]       rank;
        logic [OpLen-1:0]         op;
        logic [PayloadLen-1:0]    payload;
    } entry_t;

    localparam int unsigned EntryLen = $bits(entry_t);

    function automatic entry_t to_entry(input packet_t p);
        entry_t e;
        e.reduction = p.reduction;
        e.src       = p.src;
        e.pkttype   = p.pkttype;
        e.algtype   = p.algtype;
        e.index     = p.index;
        e.commsize  = p.commsize;
        e.root      = p.root;
        e.rank      = p.rank;
        e.op        = p.op;
        e.payload   = p.payload;
        return e;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO, parameterised width/depth (depth a power of two).
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (head, always
// visible), count (occupancy), full, empty. Push when full and pop when empty
// are ignored.
module pkt_fifo #(
    parameter int unsigned Width = 60,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           rdata,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next-state: pointers wrap naturally because Depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while count != 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/depacketer.sv
// Receive-side packet decoder. Filters incoming 64-bit packets on the valid
// bit and destination node, buffers accepted ones in pkt_fifo and presents
// the decoded head fields to the local consumer.
// Ports: clk, rst (sync, active-high); in_valid/in_packet/in_ready (network
// side); out_valid/out_ready plus out_* decoded fields (zero when
// out_valid=0); drop_pulse/drop_count drop statistics.
// Build option: define DEPACKETER_STATS_EN to include the drop counter;
// otherwise drop_pulse and drop_count are tied to 0.
module depacketer
    import pkt_pkg::*;
#(
    parameter int unsigned LocalNode  = 0,
    parameter int unsigned FifoDepth  = 4,
    parameter int unsigned CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [63:0]           in_packet,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_payload,
    output logic [4:0]            out_op,
    output logic [2:0]            out_rank,
    output logic [2:0]            out_root,
    output logic [2:0]            out_commsize,
    output logic [3:0]            out_index,
    output logic [1:0]            out_algtype,
    output logic [3:0]            out_pkttype,
    output logic [2:0]            out_src,
    output logic                  out_reduction,
    output logic                  drop_pulse,
    output logic [CountWidth-1:0] drop_count
);

    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    packet_t             pkt_in;
    entry_t              head;
    logic [EntryLen-1:0] fifo_rdata;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_full, fifo_empty;
    logic                accept, addr_ok, push, pop;

    assign pkt_in = packet_t'(in_packet);

    // Drops are consumed through the same gate as pushes: no bypass when full.
    assign in_ready  = !rst && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign addr_ok   = pkt_in.valid && (pkt_in.dst == NodeIdLen'(LocalNode));
    assign push      = accept && addr_ok;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    pkt_fifo #(
        .Width (EntryLen),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (EntryLen'(to_entry(pkt_in))),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = entry_t'(fifo_rdata);

    // Occupancy and empty flag must agree.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_empty == (fifo_count == '0));
        end
    end

    // Head fields, zeroed while nothing is buffered.
    always_comb begin
        out_payload   = '0;
        out_op        = '0;
        out_rank      = '0;
        out_root      = '0;
        out_commsize  = '0;
        out_index     = '0;
        out_algtype   = '0;
        out_pkttype   = '0;
        out_src       = '0;
        out_reduction = 1'b0;
        if (out_valid) begin
            out_payload   = head.payload;
            out_op        = head.op;
            out_rank      = head.rank;
            out_root      = head.root;
            out_commsize  = head.commsize;
            out_index     = head.index;
            out_algtype   = head.algtype;
            out_pkttype   = head.pkttype;
            out_src       = head.src;
            out_reduction = head.reduction;
        end
    end

`ifdef DEPACKETER_STATS_EN
    logic                  drop;
    logic                  drop_pulse_q, drop_pulse_d;
    logic [CountWidth-1:0] drop_count_q, drop_count_d;

    assign drop = accept && !addr_ok;

    // Saturating drop counter; holds at all-ones.
    always_comb begin
        drop_pulse_d = drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != {CountWidth{1'b1}})) begin
            drop_count_d = drop_count_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;
`else
    assign drop_pulse = 1'b0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_depacketer.sv
// Directed bench for depacketer: a vector table for single-cycle behaviour,
// plus sequences for backpressure, streaming across pointer wrap, mid-stream
// reset and drop-counter saturation.
module tb_depacketer;

`ifdef DEPACKETER_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_packet;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_payload;
    logic [4:0]  out_op;
    logic [2:0]  out_rank;
    logic [2:0]  out_root;
    logic [2:0]  out_commsize;
    logic [3:0]  out_index;
    logic [1:0]  out_algtype;
    logic [3:0]  out_pkttype;
    logic [2:0]  out_src;
    logic        out_reduction;
    logic        drop_pulse;
    logic [3:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;

    depacketer #(
        .LocalNode  (0),
        .FifoDepth  (4),
        .CountWidth (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_packet     (in_packet),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_payload   (out_payload),
        .out_op        (out_op),
        .out_rank      (out_rank),
        .out_root      (out_root),
        .out_commsize  (out_commsize),
        .out_index     (out_index),
        .out_algtype   (out_algtype),
        .out_pkttype   (out_pkttype),
        .out_src       (out_src),
        .out_reduction (out_reduction),
        .drop_pulse    (drop_pulse),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet builder; secondary fields are derived so every field is exercised.
    function automatic logic [63:0] mk(input logic v, input logic [2:0] dst,
                                       input logic [2:0] src, input logic [4:0] op,
                                       input logic [31:0] pl);
        logic [63:0] p;
        p = {v, src[0], src, dst, op[3:0], op[1:0], pl[3:0], 3'd4, src, ~src, op, pl};
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compares all out_* fields against a packet (or zeros when not valid).
    task automatic chk_out(input string name, input logic exp_v, input logic [63:0] p);
        logic [63:0] act;
        logic [63:0] exp;
        act = {1'b0, out_reduction, out_src, 3'b000, out_pkttype, out_algtype,
               out_index, out_commsize, out_root, out_rank, out_op, out_payload};
        exp = exp_v ? (p & 64'h78FF_FFFF_FFFF_FFFF) : 64'h0;
        chk({name, ".valid"}, 64'(out_valid), 64'(exp_v));
        chk({name, ".fields"}, act, exp);
    endtask

    typedef struct {
        logic        iv;
        logic [63:0] pkt;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [63:0] e_head;
        logic        e_dp;
        int          e_dc;
    } vec_t;

    // Streaming scenario with a queue model of the FIFO.
    task automatic run_stream(input string name, input int n, input int hold, input int base);
        logic [63:0] q[$];
        logic [63:0] p;
        int sent = 0;
        int cyc  = 0;
        bit acc, pp;
        while (!(sent == n && q.size() == 0)) begin
            if (cyc >= 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: timeout, sent %0d of %0d, %0d left", name, sent, n, q.size());
                break;
            end
            @(negedge clk);
            chk({name, ".in_ready"}, 64'(in_ready), 64'(q.size() != 4));
            chk_out(name, q.size() != 0, (q.size() != 0) ? q[0] : 64'h0);
            p = mk(1'b1, 3'd0, 3'(sent), 5'(sent + 3), 32'(base + sent));
            in_valid  = (sent < n);
            in_packet = (sent < n) ? p : 64'h0;
            out_ready = (cyc >= hold);
            acc = in_valid && (q.size() != 4);
            pp  = (q.size() != 0) && out_ready;
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(p);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_packet = 64'h0;
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        logic [63:0] p1, p2, p3;
        p1 = mk(1'b1, 3'd0, 3'd5, 5'd3, 32'hDEAD_BEEF);
        p2 = mk(1'b1, 3'd0, 3'd2, 5'd7, 32'h1234_5678);
        p3 = mk(1'b1, 3'd0, 3'd3, 5'd9, 32'hA5A5_0003);
        //          iv    pkt                                         ordy  irdy  ov    head   dp  dc
        vecs[0] = '{1'b1, p1,                                         1'b0, 1'b1, 1'b1, p1,    1'b0, 0};
        vecs[1] = '{1'b1, mk(1'b1, 3'd2, 3'd1, 5'd1, 32'h1111),       1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1};
        vecs[2] = '{1'b1, mk(1'b0, 3'd0, 3'd6, 5'd2, 32'h2222),       1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 2};
        vecs[3] = '{1'b0, 64'h0,                                      1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 2};
        vecs[4] = '{1'b1, p2,                                         1'b0, 1'b1, 1'b1, p2,    1'b0, 2};
        vecs[5] = '{1'b1, p3,                                         1'b1, 1'b1, 1'b1, p3,    1'b0, 2};
        vecs[6] = '{1'b1, mk(1'b1, 3'd4, 3'd7, 5'd1, 32'h3333),       1'b0, 1'b1, 1'b1, p3,    1'b1, 3};
        vecs[7] = '{1'b0, 64'h0,                                      1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_packet = 64'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'h0);
        chk_out("rst", 1'b0, 64'h0);
        chk("rst.drop_pulse", 64'(drop_pulse), 64'h0);
        chk("rst.drop_count", 64'(drop_count), 64'h0);
        rst = 1'b0;
        #1;
        chk("rst_rel.in_ready", 64'(in_ready), 64'h1);

        // Single-cycle vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            in_packet = vecs[i].pkt;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_head);
            chk($sformatf("vec%0d.drop_pulse", i), 64'(drop_pulse), 64'(vecs[i].e_dp && StatsEn));
            chk($sformatf("vec%0d.drop_count", i), 64'(drop_count), StatsEn ? 64'(vecs[i].e_dc) : 64'h0);
        end
        @(negedge clk);
        in_valid = 1'b0; in_packet = 64'h0; out_ready = 1'b0;

        // Backpressure: 5 packets into a 4-deep FIFO, consumer released later
        run_stream("full", 5, 8, 32'h1000);
        // Continuous push/pop across pointer wrap
        run_stream("stream", 11, 0, 32'h2000);

        // Mid-stream reset with three entries buffered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_packet = mk(1'b1, 3'd0, 3'(i), 5'(i), 32'h3000 + 32'(i));
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_packet = mk(1'b1, 3'd1, 3'd1, 5'd1, 32'h3100);
        @(negedge clk);
        chk_out("pre_rst", 1'b1, mk(1'b1, 3'd0, 3'd0, 5'd0, 32'h3000));
        chk("pre_rst.drop_count", 64'(drop_count), StatsEn ? 64'd4 : 64'h0);
        rst = 1'b1;
        in_packet = mk(1'b1, 3'd0, 3'd7, 5'd7, 32'h3FFF);
        #1;
        chk("in_rst.in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_packet = 64'h0;
        #1;
        chk_out("post_rst", 1'b0, 64'h0);
        chk("post_rst.in_ready", 64'(in_ready), 64'h1);
        chk("post_rst.drop_count", 64'(drop_count), 64'h0);
        chk("post_rst.drop_pulse", 64'(drop_pulse), 64'h0);
        @(negedge clk);
        chk_out("post_rst2", 1'b0, 64'h0);

        // Drop-counter saturation
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_packet = mk(1'b1, 3'(1 + (i % 7)), 3'd2, 5'd2, 32'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_packet = 64'h0;
        chk("sat.drop_count", 64'(drop_count), StatsEn ? 64'd15 : 64'h0);
        chk("sat.drop_pulse", 64'(drop_pulse), 64'(StatsEn));
        chk_out("sat", 1'b0, 64'h0);
        @(negedge clk);
        chk("sat_idle.drop_pulse", 64'(drop_pulse), 64'h0);
        chk("sat_idle.drop_count", 64'(drop_count), StatsEn ? 64'd15 : 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
